// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding and bit-time arithmetic.
// Intended for reuse by both the transmitter and the future receiver.
package uart_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StStart = START,
    StData  = DATA,
    StStop  = STOP
  } uart_state_e;

  // Clock cycles per UART bit, truncated.
  function automatic int unsigned symbol_edge_time(input int unsigned freq,
                                                   input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: free-running, synchronously clearable, and emits a
// one-cycle tick on the last cycle of each bit period.
module uart_baud_tick #(
  parameter int unsigned Period = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Period - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear has priority so a held clear never produces a stray tick.
  assign tick_o = !clr_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains words from a FIFO dequeue port and sends each as WORD_BYTES 8N1
// frames, least-significant byte and bit first, with no gap between bytes.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [8*WORD_BYTES-1:0] in_data,
  output logic                    in_ready,
  output logic                    serial_out,
  output logic                    busy
);

  localparam int unsigned SymbolEdgeTime = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned WordW          = 8 * WORD_BYTES;
  localparam int unsigned ByteIdxW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(WORD_BYTES - 1);

  if (SymbolEdgeTime < 2) begin : gen_bad_baud
    $error("fifo_uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2 cycles per bit");
  end

  uart_state_e         state_q, state_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [ByteIdxW-1:0] byte_idx_q, byte_idx_d;
  logic                serial_q, serial_d;
  logic                busy_q, busy_d;
  logic                baud_clr;
  logic                tick;
  logic                accept;

  assign in_ready   = (state_q == StIdle);
  assign accept     = in_valid && in_ready;
  assign serial_out = serial_q;
  assign busy       = busy_q;

  // Holding the counter at zero while idle aligns the first bit to the accept edge.
  assign baud_clr = (state_q == StIdle);

  uart_baud_tick #(
    .Period (SymbolEdgeTime)
  ) u_baud_tick (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (baud_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    serial_d   = serial_q;
    busy_d     = busy_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StStart;
          word_d     = in_data;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          serial_d   = 1'b0;
          busy_d     = 1'b1;
        end
      end

      // The word is a shift register: its LSB is always the next data bit,
      // since bytes and bits both go out least-significant first.
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_idx_d = '0;
          serial_d  = word_q[0];
          word_d    = word_q >> 1;
        end
      end

      StData: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d  = StStop;
            serial_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = word_q[0];
            word_d    = word_q >> 1;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (byte_idx_q == LastByte) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d    = StStart;
            byte_idx_d = byte_idx_q + ByteIdxW'(1);
            serial_d   = 1'b0;
          end
        end
      end

      default: begin
        state_d  = StIdle;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      word_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: expected bytes are queued when words are issued,
// and a UART receiver process decodes the line and checks against the queue.
module tb_fifo_uart_tx;

  localparam int unsigned Wb = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        serial_out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .WORD_BYTES (Wb)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) sbq.push_back(w[8*b +: 8]);
  endtask

  // Expected line level i cycles after the accept edge, 10 cycles per bit.
  function automatic logic exp_line(input logic [31:0] w, input int i);
    int s, b, k;
    s = i / 10;
    b = s / 10;
    k = s % 10;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return w[8*b + k - 1];
  endfunction

  // Receiver: samples mid-bit on negedges, framing-checks and scores each byte.
  initial begin : rx_monitor
    int rx_st;
    int rx_c;
    int k;
    logic [7:0] rx_byte;
    rx_st = 0;
    rx_c = 0;
    rx_byte = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rx_st = 0;
      end else if (rx_st == 0) begin
        if (serial_out === 1'b0) begin
          rx_st = 1;
          rx_c = 0;
        end
      end else begin
        rx_c++;
        if (rx_c % 10 == 5) begin
          k = rx_c / 10;
          if (k == 0) begin
            chk("start bit", {31'd0, serial_out}, 32'd0);
          end else if (k <= 8) begin
            rx_byte[k-1] = serial_out;
          end else begin
            chk("stop bit", {31'd0, serial_out}, 32'd1);
            if (sbq.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL rx byte: got unexpected %h, expected none", rx_byte);
            end else begin
              chk("rx byte", {24'd0, rx_byte}, {24'd0, sbq.pop_front()});
            end
            rx_st = 0;
          end
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    push_word(w);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL send timeout: in_ready still %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~w;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL idle timeout: in_ready=%b busy=%b, expected 1/0", in_ready, busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bad, rdy_bad, acc_n, cyc, accepts, last_acc, next;
    int acc_pos[4];
    logic acc_pending;
    logic [31:0] w;
    logic [31:0] fq[$];

    // 1. Reset
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst serial_out", {31'd0, serial_out}, 32'd1);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post-rst serial_out", {31'd0, serial_out}, 32'd1);
      chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("post-rst busy", {31'd0, busy}, 32'd0);
    end

    // 2. Single word, exact per-cycle line and ready timing
    w = 32'h1234_56A5;
    send_word(w);
    bad = 0;
    rdy_bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (serial_out !== exp_line(w, i)) bad++;
      if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
      @(posedge clk);
      #1;
    end
    chk("t2 line bad cycles", bad, 0);
    chk("t2 busy/ready bad cycles", rdy_bad, 0);
    chk("t2 in_ready after 400", {31'd0, in_ready}, 32'd1);
    chk("t2 busy after 400", {31'd0, busy}, 32'd0);
    wait_idle();
    chk("t2 scoreboard drained", sbq.size(), 0);

    // 3. in_valid held with data changing every cycle
    in_valid = 1'b1;
    acc_n = 0;
    for (int i = 0; i < 800; i++) begin
      in_data = 32'hC0DE_0000 + i;
      if (in_ready) begin
        push_word(in_data);
        if (acc_n < 4) acc_pos[acc_n] = i;
        acc_n++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("t3 accept count", acc_n, 2);
    chk("t3 first accept", acc_pos[0], 0);
    chk("t3 second accept", acc_pos[1], 401);
    wait_idle();
    chk("t3 scoreboard drained", sbq.size(), 0);

    // 4. Behind an 8-entry FIFO, 1000..1049 enqueued back-to-back
    next = 0;
    cyc = 0;
    accepts = 0;
    last_acc = 0;
    acc_pending = 1'b0;
    while (accepts < 50 && cyc < 25000) begin
      if (acc_pending) void'(fq.pop_front());
      if (next < 50 && fq.size() < 8) begin
        fq.push_back(32'(1000 + next));
        push_word(32'(1000 + next));
        next++;
      end
      in_valid = (fq.size() > 0);
      in_data  = in_valid ? fq[0] : 32'd0;
      acc_pending = in_valid && in_ready;
      if (acc_pending) begin
        if (accepts > 0) chk("t4 accept spacing", cyc - last_acc, 401);
        last_acc = cyc;
        accepts++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (acc_pending) void'(fq.pop_front());
    in_valid = 1'b0;
    chk("t4 words accepted", accepts, 50);
    chk("t4 fifo empty", fq.size(), 0);
    wait_idle();
    chk("t4 scoreboard drained", sbq.size(), 0);

    // 5. All-zero and all-one words
    send_word(32'h0000_0000);
    wait_idle();
    send_word(32'hFFFF_FFFF);
    wait_idle();
    chk("t5 scoreboard drained", sbq.size(), 0);

    // 6. Reset in the middle of byte 2, then a clean word
    w = 32'hDEAD_BEEF;
    send_word(w);
    repeat (225) begin
      @(posedge clk);
      #1;
    end
    chk("t6 line before rst", {31'd0, serial_out}, {31'd0, exp_line(w, 225)});
    #2;
    rst = 1'b0;
    #1;
    chk("t6 serial_out on rst", {31'd0, serial_out}, 32'd1);
    chk("t6 busy on rst", {31'd0, busy}, 32'd0);
    chk("t6 in_ready on rst", {31'd0, in_ready}, 32'd1);
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6 in_ready after release", {31'd0, in_ready}, 32'd1);
    chk("t6 serial_out after release", {31'd0, serial_out}, 32'd1);
    send_word(32'hCAFE_F00D);
    wait_idle();
    chk("t6 scoreboard drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
